wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/wb_arbiter.sv | 97 +++++++++
 tb/tb_wb_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared defaults and source indices for the writeback arbiter.
package wb_pkg;
  localparam int XLEN_DEF    = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int NUM_SRC_DEF = 3;

  localparam int SRC_LOAD = 0;
  localparam int SRC_ALU  = 1;
  localparam int SRC_FP   = 2;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer;
// the pointer moves past the winner whenever a grant is consumed.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic [PW-1:0] gnt_idx;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    found   = 1'b0;
    idx     = ptr;
    for (int k = 0; k < N; k++) begin
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
      idx = (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: independent round-robin per destination class (integer / FP)
// feeding one registered write port per regfile.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC-1:0]        src_is_fp,
  input  logic [NUM_SRC*XLEN-1:0]   src_data,
  input  logic [NUM_SRC*ADDR_W-1:0] src_rd,
  input  logic                      rf_hold,
  output logic                      int_we,
  output logic [ADDR_W-1:0]         int_waddr,
  output logic [XLEN-1:0]           int_wdata,
  output logic                      fp_we,
  output logic [ADDR_W-1:0]         fp_waddr,
  output logic [XLEN-1:0]           fp_wdata
);
  logic [NUM_SRC-1:0] int_req, fp_req;
  logic [NUM_SRC-1:0] int_gnt, fp_gnt;
  logic               int_xfer, fp_xfer, int_wr;
  logic [XLEN-1:0]    int_sel_data, fp_sel_data;
  logic [ADDR_W-1:0]  int_sel_rd, fp_sel_rd;

  // Masking requests during reset keeps src_ready low while rst is held.
  assign int_req = (rst || rf_hold) ? '0 : (src_valid & ~src_is_fp);
  assign fp_req  = (rst || rf_hold) ? '0 : (src_valid &  src_is_fp);

  assign int_xfer = |int_gnt;
  assign fp_xfer  = |fp_gnt;

  rr_arbiter #(.N(NUM_SRC)) u_int_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (int_req),
    .advance (int_xfer),
    .gnt     (int_gnt)
  );

  rr_arbiter #(.N(NUM_SRC)) u_fp_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (fp_req),
    .advance (fp_xfer),
    .gnt     (fp_gnt)
  );

  assign src_ready = int_gnt | fp_gnt;

  always_comb begin
    int_sel_data = '0;
    int_sel_rd   = '0;
    fp_sel_data  = '0;
    fp_sel_rd    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (int_gnt[i]) begin
        int_sel_data = src_data[i*XLEN +: XLEN];
        int_sel_rd   = src_rd[i*ADDR_W +: ADDR_W];
      end
      if (fp_gnt[i]) begin
        fp_sel_data = src_data[i*XLEN +: XLEN];
        fp_sel_rd   = src_rd[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // x0 is hardwired zero: the transfer is consumed but never written.
  assign int_wr = int_xfer && (int_sel_rd != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_we    <= 1'b0;
      int_waddr <= '0;
      int_wdata <= '0;
      fp_we     <= 1'b0;
      fp_waddr  <= '0;
      fp_wdata  <= '0;
    end else begin
      int_we <= int_wr;
      if (int_wr) begin
        int_waddr <= int_sel_rd;
        int_wdata <= int_sel_data;
      end
      fp_we <= fp_xfer;
      if (fp_xfer) begin
        fp_waddr <= fp_sel_rd;
        fp_wdata <= fp_sel_data;
      end
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// compared against a queue-free behavioural model of the per-class round robin.
module tb_wb_arbiter;
  localparam int N  = 3;
  localparam int XL = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  src_valid, src_ready, src_is_fp;
  logic [N*XL-1:0] src_data;
  logic [N*AW-1:0] src_rd;
  logic          rf_hold;
  logic          int_we, fp_we;
  logic [AW-1:0] int_waddr, fp_waddr;
  logic [XL-1:0] int_wdata, fp_wdata;

  logic          v [N];
  logic          f [N];
  logic [AW-1:0] rd [N];
  logic [XL-1:0] d [N];

  assign src_valid = {v[2], v[1], v[0]};
  assign src_is_fp = {f[2], f[1], f[0]};
  assign src_rd    = {rd[2], rd[1], rd[0]};
  assign src_data  = {d[2], d[1], d[0]};

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(XL), .NUM_SRC(N), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_is_fp (src_is_fp),
    .src_data  (src_data),
    .src_rd    (src_rd),
    .rf_hold   (rf_hold),
    .int_we    (int_we),
    .int_waddr (int_waddr),
    .int_wdata (int_wdata),
    .fp_we     (fp_we),
    .fp_waddr  (fp_waddr),
    .fp_wdata  (fp_wdata)
  );

  int checks   = 0;
  int failures = 0;

  // reference model state
  int            m_iptr, m_fptr;
  logic          m_iwe, m_fwe;
  logic [AW-1:0] m_iwa, m_fwa;
  logic [XL-1:0] m_iwd, m_fwd;
  int            last_gi, last_gf;

  function automatic int pick(input int ptr, input logic want_fp);
    if (rst || rf_hold) return -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr + k) % N;
      if (v[j] && f[j] == want_fp) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int gi, gf;
    logic [N-1:0] r;
    r  = '0;
    gi = pick(m_iptr, 1'b0);
    gf = pick(m_fptr, 1'b1);
    if (gi >= 0) r = r | (N'(1) << gi);
    if (gf >= 0) r = r | (N'(1) << gf);
    return r;
  endfunction

  task automatic model_reset();
    m_iptr = 0; m_fptr = 0;
    m_iwe = 1'b0; m_fwe = 1'b0;
    m_iwa = '0; m_fwa = '0; m_iwd = '0; m_fwd = '0;
    last_gi = -1; last_gf = -1;
  endtask

  task automatic advance_clk();
    int gi, gf;
    gi = pick(m_iptr, 1'b0);
    gf = pick(m_fptr, 1'b1);
    @(posedge clk);
    last_gi = gi; last_gf = gf;
    m_iwe = 1'b0; m_fwe = 1'b0;
    if (gi >= 0) begin
      m_iptr = (gi + 1) % N;
      if (rd[gi] != '0) begin
        m_iwe = 1'b1; m_iwa = rd[gi]; m_iwd = d[gi];
      end
    end
    if (gf >= 0) begin
      m_fptr = (gf + 1) % N;
      m_fwe = 1'b1; m_fwa = rd[gf]; m_fwd = d[gf];
    end
    if (rst) model_reset();
    #1;
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; f[i] = 1'b0; rd[i] = '0; d[i] = '0;
    end
    rf_hold = 1'b0;
  endtask

  task automatic do_reset();
    clear_sources();
    rst = 1'b1;
    model_reset();
    advance_clk();
    advance_clk();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b1; f[i] = (i == 2); rd[i] = AW'(i + 1); d[i] = XL'(32'h100 + i);
    end
    rf_hold = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #4;
      checks++; if (src_ready !== '0) begin failures++; $display("FAIL reset_ready: got %b expected 000", src_ready); end
      checks++; if (int_we !== 1'b0 || fp_we !== 1'b0) begin failures++; $display("FAIL reset_we: got int %b fp %b expected 0 0", int_we, fp_we); end
      checks++; if (int_waddr !== '0 || fp_waddr !== '0) begin failures++; $display("FAIL reset_waddr: got int %0d fp %0d expected 0 0", int_waddr, fp_waddr); end
      checks++; if (int_wdata !== '0 || fp_wdata !== '0) begin failures++; $display("FAIL reset_wdata: got int %h fp %h expected 0 0", int_wdata, fp_wdata); end
      advance_clk();
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b1; f[i] = 1'b0; rd[i] = AW'(i + 1); d[i] = XL'(32'hA + i);
    end
    for (int c = 0; c < 7; c++) begin
      #4;
      checks++;
      if (src_ready !== (N'(1) << (c % N))) begin
        failures++; $display("FAIL rr_ready cycle %0d: got %b expected %b", c, src_ready, N'(1) << (c % N));
      end
      if (c > 0) begin
        checks++;
        if (int_we !== 1'b1 || int_waddr !== AW'((c - 1) % N + 1) || int_wdata !== XL'(32'hA + (c - 1) % N)) begin
          failures++;
          $display("FAIL rr_write cycle %0d: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                   c, int_we, int_waddr, int_wdata, (c - 1) % N + 1, 32'hA + (c - 1) % N);
        end
      end else begin
        checks++; if (int_we !== 1'b0) begin failures++; $display("FAIL rr_first_we: got %b expected 0", int_we); end
      end
      checks++; if (fp_we !== 1'b0) begin failures++; $display("FAIL rr_fp_we cycle %0d: got %b expected 0", c, fp_we); end
      advance_clk();
    end
  endtask

  task automatic test_dual_class();
    do_reset();
    v[0] = 1'b1; f[0] = 1'b0; rd[0] = 5'd4; d[0] = 32'h1111;
    v[2] = 1'b1; f[2] = 1'b1; rd[2] = 5'd7; d[2] = 32'h3F800000;
    #4;
    checks++; if (src_ready !== 3'b101) begin failures++; $display("FAIL dual_ready: got %b expected 101", src_ready); end
    advance_clk();
    v[0] = 1'b0; v[2] = 1'b0;
    #4;
    checks++;
    if (int_we !== 1'b1 || int_waddr !== 5'd4 || int_wdata !== 32'h1111) begin
      failures++; $display("FAIL dual_int: got we=%b addr=%0d data=%h expected we=1 addr=4 data=00001111", int_we, int_waddr, int_wdata);
    end
    checks++;
    if (fp_we !== 1'b1 || fp_waddr !== 5'd7 || fp_wdata !== 32'h3F800000) begin
      failures++; $display("FAIL dual_fp: got we=%b addr=%0d data=%h expected we=1 addr=7 data=3f800000", fp_we, fp_waddr, fp_wdata);
    end
    advance_clk();
    #4;
    checks++;
    if (int_we !== 1'b0 || fp_we !== 1'b0 || int_waddr !== 5'd4 || fp_waddr !== 5'd7 || int_wdata !== 32'h1111) begin
      failures++; $display("FAIL dual_hold: got we=%b/%b addr=%0d/%0d expected we=0/0 addr=4/7", int_we, fp_we, int_waddr, fp_waddr);
    end
    advance_clk();
  endtask

  task automatic test_rd_zero();
    do_reset();
    v[0] = 1'b1; f[0] = 1'b0; rd[0] = 5'd0; d[0] = 32'hDEAD;
    v[1] = 1'b1; f[1] = 1'b0; rd[1] = 5'd6; d[1] = 32'h66;
    #4;
    checks++; if (src_ready !== 3'b001) begin failures++; $display("FAIL rd0_ready: got %b expected 001", src_ready); end
    advance_clk();
    #4;
    checks++; if (int_we !== 1'b0) begin failures++; $display("FAIL rd0_we: got %b expected 0", int_we); end
    checks++; if (src_ready !== 3'b010) begin failures++; $display("FAIL rd0_next_grant: got %b expected 010", src_ready); end
    advance_clk();
    v[1] = 1'b0;
    #4;
    checks++;
    if (int_we !== 1'b1 || int_waddr !== 5'd6 || int_wdata !== 32'h66) begin
      failures++; $display("FAIL rd0_follow_write: got we=%b addr=%0d data=%h expected we=1 addr=6 data=00000066", int_we, int_waddr, int_wdata);
    end
    advance_clk();
  endtask

  task automatic test_hold();
    do_reset();
    v[1] = 1'b1; f[1] = 1'b0; rd[1] = 5'd9; d[1] = 32'h99;
    rf_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #4;
      checks++;
      if (src_ready !== 3'b000 || int_we !== 1'b0 || fp_we !== 1'b0) begin
        failures++; $display("FAIL hold_cycle %0d: got ready=%b we=%b/%b expected 000 0/0", c, src_ready, int_we, fp_we);
      end
      advance_clk();
    end
    rf_hold = 1'b0;
    #4;
    checks++; if (int_we !== 1'b0 || src_ready !== 3'b010) begin failures++; $display("FAIL hold_release: got we=%b ready=%b expected 0 010", int_we, src_ready); end
    advance_clk();
    v[1] = 1'b0;
    #4;
    checks++;
    if (int_we !== 1'b1 || int_waddr !== 5'd9) begin
      failures++; $display("FAIL hold_write: got we=%b addr=%0d expected we=1 addr=9", int_we, int_waddr);
    end
    advance_clk();
    #4;
    checks++; if (int_we !== 1'b0) begin failures++; $display("FAIL hold_single_pulse: got %b expected 0", int_we); end
    advance_clk();
  endtask

  task automatic test_reset_mid();
    do_reset();
    v[0] = 1'b1; f[0] = 1'b0; rd[0] = 5'd5; d[0] = 32'h55;
    #4;
    checks++; if (src_ready !== 3'b001) begin failures++; $display("FAIL midrst_accept: got %b expected 001", src_ready); end
    advance_clk();
    rst = 1'b1;
    model_reset();
    v[0] = 1'b0;
    v[1] = 1'b1; f[1] = 1'b0; rd[1] = 5'd11; d[1] = 32'hB1;
    v[2] = 1'b1; f[2] = 1'b0; rd[2] = 5'd12; d[2] = 32'hC2;
    #4;
    checks++; if (int_we !== 1'b0 || src_ready !== 3'b000) begin failures++; $display("FAIL midrst_flush: got we=%b ready=%b expected 0 000", int_we, src_ready); end
    advance_clk();
    rst = 1'b0;
    #4;
    checks++; if (int_we !== 1'b0) begin failures++; $display("FAIL midrst_no_pulse: got %b expected 0", int_we); end
    checks++; if (src_ready !== 3'b010) begin failures++; $display("FAIL midrst_first_grant: got %b expected 010", src_ready); end
    advance_clk();
    #4;
    checks++;
    if (int_we !== 1'b1 || int_waddr !== 5'd11) begin
      failures++; $display("FAIL midrst_write: got we=%b addr=%0d expected we=1 addr=11", int_we, int_waddr);
    end
    advance_clk();
  endtask

  task automatic test_random();
    int wt [N];
    do_reset();
    for (int i = 0; i < N; i++) wt[i] = 0;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] || i == last_gi || i == last_gf) begin
          v[i]  = ($urandom % 4) != 0;
          f[i]  = 1'($urandom % 2);
          rd[i] = (($urandom % 8) == 0) ? 5'd0 : AW'($urandom);
          d[i]  = $urandom;
          wt[i] = 0;
        end
      end
      rf_hold = (($urandom % 8) == 0);
      #4;
      checks++; if (src_ready !== exp_ready()) begin failures++; $display("FAIL rand_ready cycle %0d: got %b expected %b", c, src_ready, exp_ready()); end
      checks++;
      if (int_we !== m_iwe || int_waddr !== m_iwa || int_wdata !== m_iwd) begin
        failures++; $display("FAIL rand_int cycle %0d: got we=%b addr=%0d data=%h expected we=%b addr=%0d data=%h",
                             c, int_we, int_waddr, int_wdata, m_iwe, m_iwa, m_iwd);
      end
      checks++;
      if (fp_we !== m_fwe || fp_waddr !== m_fwa || fp_wdata !== m_fwd) begin
        failures++; $display("FAIL rand_fp cycle %0d: got we=%b addr=%0d data=%h expected we=%b addr=%0d data=%h",
                             c, fp_we, fp_waddr, fp_wdata, m_fwe, m_fwa, m_fwd);
      end
      advance_clk();
      // a waiting source may see at most N-1 other transfers in its class
      for (int i = 0; i < N; i++) begin
        int g;
        g = f[i] ? last_gf : last_gi;
        if (v[i] && g >= 0 && g != i) begin
          wt[i]++;
          checks++;
          if (wt[i] > N - 1) begin failures++; $display("FAIL rand_fairness src %0d: waited %0d transfers, limit %0d", i, wt[i], N - 1); end
        end
      end
    end
    rf_hold = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    clear_sources();
    rst = 1'b1;
    model_reset();
    advance_clk();
    test_reset();
    test_round_robin();
    test_dual_class();
    test_rd_zero();
    test_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
